gc_port_arbiter: RTL
====================

Name: gc_port_arbiter

Overview:
- Shares the single read/write port of the gain-curve RAM between two requesters.
- Requester F is the FFT-domain audio path: it reads one gain per bin and has priority.
- Requester E is the gain-curve editor/recompute engine: it reads and writes, and can lock the port for read-modify-write sequences.
- The block issues registered RAM commands, tags in-flight reads and routes read data back to the owner.
- It bounds starvation of either requester.

Parameters:
- LOGFFTSIZE, 10, gain-curve address width (one entry per FFT bin).
- AUDIOWIDTH, 16, gain-curve data width.
- RDLAT, 2, RAM read latency in cycles from ram_addr registered to ram_dout valid (1..4).
- MAXSTARVE, 15, max consecutive denied cycles before forced service / overrun flag (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- f_req  in  1  audio path read request
- f_addr  in  LOGFFTSIZE  audio path bin address
- f_gnt  out  1  audio path request accepted this cycle (combinational)
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  AUDIOWIDTH  gain read for audio path
- f_overrun  out  1  sticky: F denied more than MAXSTARVE consecutive cycles
- e_req  in  1  editor access request
- e_we  in  1  editor write enable (qualifies e_req)
- e_lock  in  1  editor holds port across accesses
- e_addr  in  LOGFFTSIZE  editor address
- e_din  in  AUDIOWIDTH  editor write data
- e_gnt  out  1  editor request accepted this cycle (combinational)
- e_rvalid  out  1  e_rdata valid
- e_rdata  out  AUDIOWIDTH  read data for editor
- ram_addr  out  LOGFFTSIZE  RAM address (registered)
- ram_din  out  AUDIOWIDTH  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_dout  in  AUDIOWIDTH  RAM read data
- busy  out  1  any access issued or read in flight

Behaviour:
- Reset: every output is 0, including f_overrun, ram_addr, ram_din and ram_we. The FSM goes to ST_FREE, both starve counters clear and the tag pipeline clears. Reads in flight at reset are dropped; no rvalid is produced for them.
- The FSM has two states, ST_FREE and ST_ELOCK.
- ST_FREE grant rule, evaluated every cycle:
  - Only F requests: f_gnt = 1.
  - Only E requests: e_gnt = 1.
  - Both request and e_starve < MAXSTARVE: f_gnt = 1.
  - Both request and e_starve == MAXSTARVE: e_gnt = 1 (forced service).
  - f_gnt and e_gnt are never both 1.
- ST_FREE to ST_ELOCK when e_gnt & e_lock.
- ST_ELOCK:
  - E has absolute priority; f_gnt = 0.
  - e_gnt = e_req.
  - Return to ST_FREE on the first cycle with e_lock = 0. That cycle uses ST_FREE rules.
- e_starve: increments (saturating at MAXSTARVE) on each cycle with e_req & !e_gnt. It clears on e_gnt or !e_req.
- f_starve: same rule for F, using f_req & !f_gnt. When it reaches MAXSTARVE and F is denied again, f_overrun sets. f_overrun clears only on rst.
- Issue timing:
  - A grant in cycle N drives ram_addr/ram_din/ram_we in cycle N+1.
  - ram_we = 1 only for an E write grant.
  - An F grant always produces a read.
  - With no grant, ram_we = 0 and ram_addr/ram_din hold their last values.
- Read tag pipeline:
  - Depth RDLAT; each entry holds {valid, owner}.
  - A read issued at N+1 produces owner_rvalid = 1 at cycle N+1+RDLAT, with rdata = ram_dout sampled that cycle.
  - Default timing: grant at N, data at N+3.
  - Writes produce no rvalid.
  - f_rdata/e_rdata hold their last value when rvalid = 0.
- Back-to-back grants are fully pipelined, one access per cycle, and reads return in issue order.
- Read-after-write: an E write granted at N followed by a read of the same address granted at N+1 must return the new data. The RAM is write-first; the arbiter adds no forwarding.
- busy = (a grant this cycle) | ram_we | (any valid tag).
- Simultaneous e_lock deassert and e_req in ST_ELOCK: the ST_FREE rule applies, so F wins if it is requesting.

Test Plan:
- Only f_req with f_addr = 5 at cycle 10, RAM[5] = 0x0100: f_gnt at 10, ram_addr = 5 at 11, f_rvalid = 1 with f_rdata = 0x0100 at 13, e_rvalid stays 0.
- f_req and e_req held continuously, MAXSTARVE = 15: f_gnt for 15 cycles, then e_gnt for exactly 1 cycle, then the pattern repeats. f_overrun stays 0.
- E write, e_addr = 7, e_din = 0x0008, then an E read of address 7 on the next cycle: ram_we pulses once, e_rdata = 0x0008 three cycles after the read grant.
- e_lock held 20 cycles with f_req continuous: f_gnt = 0 throughout, and f_overrun sets on the 16th denied cycle and stays 1 after the lock releases. After release, the first cycle with f_req gives f_gnt = 1.
- Alternating F and E reads every cycle: rvalids return in issue order, each routed to the correct owner, with no cross-delivery.
- rst asserted with 2 reads in flight: no rvalid afterwards, all outputs 0 on the cycle after rst, and f_overrun cleared.

Source files
------------

// File: rtl/gc_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gc_port_arbiter
// Purpose  : Shares the single read/write port of the gain-curve RAM between
//            the FFT-domain audio path (F, read-only, priority) and the
//            gain-curve editor (E, read/write, may lock the port for
//            read-modify-write). Issues registered RAM commands, tags reads
//            in flight and routes returning data to its owner. Starvation of
//            either side is bounded by MAXSTARVE.
// Ports    : clk, rst                       - clock, sync active-high reset
//            f_req/f_addr/f_gnt             - audio path request/accept
//            f_rvalid/f_rdata/f_overrun     - audio read return, sticky overrun
//            e_req/e_we/e_lock/e_addr/e_din - editor request, write, lock
//            e_gnt/e_rvalid/e_rdata         - editor accept and read return
//            ram_addr/ram_din/ram_we        - registered RAM command
//            ram_dout                       - RAM read data
//            busy                           - grant, write or read in flight
// Revision : 1.0 - initial release
// ============================================================================
module gc_port_arbiter #(
    parameter int LOGFFTSIZE = 10,
    parameter int AUDIOWIDTH = 16,
    parameter int RDLAT      = 2,
    parameter int MAXSTARVE  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req,
    input  logic [LOGFFTSIZE-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [AUDIOWIDTH-1:0] f_rdata,
    output logic                  f_overrun,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic                  e_lock,
    input  logic [LOGFFTSIZE-1:0] e_addr,
    input  logic [AUDIOWIDTH-1:0] e_din,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [AUDIOWIDTH-1:0] e_rdata,
    output logic [LOGFFTSIZE-1:0] ram_addr,
    output logic [AUDIOWIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [AUDIOWIDTH-1:0] ram_dout,
    output logic                  busy
);

    localparam logic [7:0] C_MAXSTARVE = 8'(MAXSTARVE);

    typedef enum logic [0:0] {
        ST_FREE  = 1'b0,
        ST_ELOCK = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_e_starve;
    logic [7:0]              r_f_starve;
    logic                    r_f_overrun;
    logic                    w_free_rules;
    logic                    w_e_forced;
    logic                    w_f_gnt;
    logic                    w_e_gnt;
    logic                    w_rd_issue;
    logic [LOGFFTSIZE-1:0]   r_ram_addr;
    logic [AUDIOWIDTH-1:0]   r_ram_din;
    logic                    r_ram_we;
    // Stage 0 lines up with the cycle the command sits on ram_addr; stage
    // RDLAT lines up with the cycle ram_dout carries that read's data.
    logic [RDLAT:0]          r_tag_v;
    logic [RDLAT:0]          r_tag_e;
    logic                    w_f_rvalid;
    logic                    w_e_rvalid;
    logic [AUDIOWIDTH-1:0]   r_f_hold;
    logic [AUDIOWIDTH-1:0]   r_e_hold;

    // ------------------------------------------------------------------
    // Grant / next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_f_gnt      = 1'b0;
        w_e_gnt      = 1'b0;
        w_state_nxt  = r_state;
        // Dropping e_lock in ST_ELOCK hands that very cycle back to the
        // free-arbitration rules, so F can win it.
        w_free_rules = (r_state == ST_FREE) || !e_lock;
        w_e_forced   = e_req && (r_e_starve == C_MAXSTARVE);
        if (w_free_rules) begin
            w_f_gnt     = f_req && !w_e_forced;
            w_e_gnt     = e_req && !w_f_gnt;
            w_state_nxt = (w_e_gnt && e_lock) ? ST_ELOCK : ST_FREE;
        end else begin
            w_e_gnt     = e_req;
            w_state_nxt = ST_ELOCK;
        end
    end

    assign w_rd_issue = w_f_gnt || (w_e_gnt && !e_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counters (saturating) and sticky overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_starve  <= 8'd0;
            r_f_starve  <= 8'd0;
            r_f_overrun <= 1'b0;
        end else begin
            if (e_req && !w_e_gnt) begin
                if (r_e_starve != C_MAXSTARVE) begin
                    r_e_starve <= r_e_starve + 8'd1;
                end
            end else begin
                r_e_starve <= 8'd0;
            end
            if (f_req && !w_f_gnt) begin
                if (r_f_starve != C_MAXSTARVE) begin
                    r_f_starve <= r_f_starve + 8'd1;
                end else begin
                    r_f_overrun <= 1'b1;
                end
            end else begin
                r_f_starve <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered RAM command; address/data hold when idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
        end else if (w_e_gnt) begin
            r_ram_addr <= e_addr;
            r_ram_din  <= e_din;
            r_ram_we   <= e_we;
        end else if (w_f_gnt) begin
            r_ram_addr <= f_addr;
            r_ram_we   <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read tag pipeline {valid, owner}; owner bit set means editor
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            r_tag_e <= '0;
        end else begin
            r_tag_v <= {r_tag_v[RDLAT-1:0], w_rd_issue};
            r_tag_e <= {r_tag_e[RDLAT-1:0], w_e_gnt};
        end
    end

    assign w_f_rvalid = r_tag_v[RDLAT] && !r_tag_e[RDLAT];
    assign w_e_rvalid = r_tag_v[RDLAT] &&  r_tag_e[RDLAT];

    // Read data is passed straight from ram_dout in the valid cycle and
    // held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_hold <= '0;
            r_e_hold <= '0;
        end else begin
            if (w_f_rvalid) begin
                r_f_hold <= ram_dout;
            end
            if (w_e_rvalid) begin
                r_e_hold <= ram_dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign f_gnt     = w_f_gnt;
    assign e_gnt     = w_e_gnt;
    assign f_rvalid  = w_f_rvalid;
    assign e_rvalid  = w_e_rvalid;
    assign f_rdata   = w_f_rvalid ? ram_dout : r_f_hold;
    assign e_rdata   = w_e_rvalid ? ram_dout : r_e_hold;
    assign f_overrun = r_f_overrun;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;
    assign busy      = w_f_gnt || w_e_gnt || r_ram_we || (|r_tag_v);

endmodule
`default_nettype wire
